mp_loop_sequencer: RTL and testbench

Top-level controller for the matching-pursuit processor. On `start` it copies the signal RAM (y) into the residual RAM (r) while computing the initial residual energy. It then runs up to K iterations of three sub-unit phases: inner products (Φᵀr), max identification, and residual/x update. Stop condition is residual energy at or below a threshold, or K iterations reached. It owns all start/done handshakes to those sub-units and replaces ad-hoc sequencing at the processor top.

---
 rtl/mp_loop_sequencer.sv | 141 ++++++++++++++
 tb/tb_mp_loop_sequencer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mp_loop_sequencer.sv
// rtl/mp_loop_sequencer.sv - matching-pursuit top-level loop sequencer
// Copies y into r with energy accumulation, then drives products/max/update phases until a stop condition.
module mp_loop_sequencer #(
  parameter int SIGNAL_ADDR_WIDTH = 6,
  parameter int FP_WIDTH          = 32,
  parameter int FP_Q              = 15,
  parameter int ITER_WIDTH        = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  input  logic [ITER_WIDTH-1:0]        max_iterations,
  input  logic [2*FP_WIDTH-1:0]        energy_threshold,
  output logic [SIGNAL_ADDR_WIDTH-1:0] y_read_addr,
  input  logic [FP_WIDTH-1:0]          y_read_data,
  output logic                         r_write_en,
  output logic [SIGNAL_ADDR_WIDTH-1:0] r_write_addr,
  output logic [FP_WIDTH-1:0]          r_write_data,
  output logic                         products_start,
  input  logic                         products_done,
  output logic                         max_start,
  input  logic                         max_done,
  output logic                         update_start,
  input  logic                         update_done,
  input  logic [2*FP_WIDTH-1:0]        update_energy,
  output logic                         busy,
  output logic                         done,
  output logic [ITER_WIDTH-1:0]        iteration,
  output logic [1:0]                   stop_reason,
  output logic [2*FP_WIDTH-1:0]        residual_energy
);

  localparam int EW = 2 * FP_WIDTH;
  localparam logic [SIGNAL_ADDR_WIDTH:0] COPY_END = (SIGNAL_ADDR_WIDTH + 1)'(1 << SIGNAL_ADDR_WIDTH);

  typedef enum logic [2:0] {IDLE, COPY, PROD, MAX, UPDATE, CHECK, FINISH} state_t;

  state_t state, state_next, prev_state;

  logic [SIGNAL_ADDR_WIDTH:0]   addr_cnt;
  logic [ITER_WIDTH-1:0]        k_reg;
  logic [EW-1:0]                thr_reg;
  logic                         wen;
  logic [SIGNAL_ADDR_WIDTH-1:0] waddr;
  logic [ITER_WIDTH-1:0]        iter_cnt;
  logic [1:0]                   reason;
  logic [EW-1:0]                energy;

  logic signed [EW-1:0] y_ext;
  logic signed [EW-1:0] square;
  logic [EW-1:0]        sq_shr;
  logic [EW:0]          acc_sum;

  // The square of any FP_WIDTH signed word fits a 2*FP_WIDTH signed product, so it is never negative.
  assign y_ext   = {{FP_WIDTH{y_read_data[FP_WIDTH-1]}}, y_read_data};
  assign square  = y_ext * y_ext;
  assign sq_shr  = square >>> FP_Q;
  assign acc_sum = {1'b0, energy} + {1'b0, sq_shr};

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      prev_state <= IDLE;
    end else begin
      prev_state <= state;
      state      <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = COPY;
      COPY:    if (addr_cnt == COPY_END) state_next = CHECK;
      PROD:    if (products_done) state_next = MAX;
      MAX:     if (max_done) state_next = UPDATE;
      UPDATE:  if (update_done) state_next = CHECK;
      CHECK: begin
        if (energy <= thr_reg)       state_next = FINISH;
        else if (iter_cnt == k_reg)  state_next = FINISH;
        else                         state_next = PROD;
      end
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      addr_cnt <= '0;
      k_reg    <= '0;
      thr_reg  <= '0;
      wen      <= 1'b0;
      waddr    <= '0;
      iter_cnt <= '0;
      reason   <= 2'd0;
      energy   <= '0;
    end else begin
      // Write path trails the read address by one cycle to match the RAM read latency.
      wen   <= (state == COPY) && (addr_cnt != COPY_END);
      waddr <= addr_cnt[SIGNAL_ADDR_WIDTH-1:0];
      if (wen) energy <= acc_sum[EW] ? {EW{1'b1}} : acc_sum[EW-1:0];
      case (state)
        IDLE: if (start) begin
          k_reg    <= max_iterations;
          thr_reg  <= energy_threshold;
          iter_cnt <= '0;
          reason   <= 2'd0;
          energy   <= '0;
          addr_cnt <= '0;
        end
        COPY: if (addr_cnt != COPY_END) addr_cnt <= addr_cnt + 1'b1;
        UPDATE: if (update_done) begin
          iter_cnt <= iter_cnt + ITER_WIDTH'(1);
          energy   <= update_energy;
        end
        CHECK: begin
          if (energy <= thr_reg)      reason <= 2'd1;
          else if (iter_cnt == k_reg) reason <= 2'd2;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy            = (state != IDLE);
    done            = (state == FINISH);
    products_start  = (state == PROD)   && (prev_state != PROD);
    max_start       = (state == MAX)    && (prev_state != MAX);
    update_start    = (state == UPDATE) && (prev_state != UPDATE);
    y_read_addr     = addr_cnt[SIGNAL_ADDR_WIDTH-1:0];
    r_write_en      = wen;
    r_write_addr    = waddr;
    r_write_data    = wen ? y_read_data : '0;
    iteration       = iter_cnt;
    stop_reason     = reason;
    residual_energy = energy;
  end

endmodule

// File: tb/tb_mp_loop_sequencer.sv
// tb/tb_mp_loop_sequencer.sv - self-checking bench for mp_loop_sequencer
// A schedule model predicts every output per cycle from the run parameters; one process compares.
module tb_mp_loop_sequencer;
  localparam int N    = 64;
  localparam int MAXC = 1024;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset, start, products_done, max_done, update_done;
  logic [7:0]  max_iterations;
  logic [63:0] energy_threshold, update_energy;
  logic [31:0] y_read_data;
  logic [5:0]  y_read_addr, r_write_addr;
  logic        r_write_en, products_start, max_start, update_start, busy, done;
  logic [31:0] r_write_data;
  logic [7:0]  iteration;
  logic [1:0]  stop_reason;
  logic [63:0] residual_energy;

  mp_loop_sequencer dut (
    .clock(clock), .reset(reset), .start(start), .max_iterations(max_iterations),
    .energy_threshold(energy_threshold), .y_read_addr(y_read_addr), .y_read_data(y_read_data),
    .r_write_en(r_write_en), .r_write_addr(r_write_addr), .r_write_data(r_write_data),
    .products_start(products_start), .products_done(products_done),
    .max_start(max_start), .max_done(max_done), .update_start(update_start),
    .update_done(update_done), .update_energy(update_energy), .busy(busy), .done(done),
    .iteration(iteration), .stop_reason(stop_reason), .residual_energy(residual_energy)
  );

  int n_cmp = 0, n_fail = 0, cyc = 0;
  bit active = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  logic [31:0] y [N];
  int lp [16], lm [16], lu [16];
  logic [63:0] en [16];
  int rk, rst_at;
  logic [63:0] rthr;

  bit i_st [MAXC], i_rs [MAXC], i_pd [MAXC], i_md [MAXC], i_ud [MAXC];
  logic [63:0] i_ue [MAXC];
  bit e_busy [MAXC], e_done [MAXC], e_ps [MAXC], e_ms [MAXC], e_us [MAXC];
  bit e_wen [MAXC], e_yv [MAXC], e_sv [MAXC], e_zero [MAXC];
  logic [5:0]  e_ya [MAXC], e_wa [MAXC];
  logic [31:0] e_wd [MAXC];
  logic [7:0]  e_it [MAXC];
  logic [1:0]  e_sr [MAXC];
  logic [63:0] e_en [MAXC];
  int last_cyc, first_p;

  int n_ps, n_ms, n_us, n_wen, n_done, done_at;
  logic [7:0]  d_it;
  logic [1:0]  d_sr;
  logic [63:0] d_en;

  task automatic set_stat(input int a, input int b, input int it, input logic [63:0] e, input int sr);
    for (int k = a; k <= b; k++) begin
      e_sv[k] = 1; e_it[k] = 8'(it); e_en[k] = e; e_sr[k] = 2'(sr);
    end
  endtask

  // Builds the per-cycle stimulus and expected outputs for one run; start is issued in cycle 2.
  task automatic plan();
    int s, c, p, m, u, d, f, it, sr;
    logic [64:0] acc;
    logic [63:0] cur;
    longint sq;
    for (int k = 0; k < MAXC; k++) begin
      i_st[k] = 0; i_rs[k] = 0; i_pd[k] = 0; i_md[k] = 0; i_ud[k] = 0; i_ue[k] = '0;
      e_busy[k] = 0; e_done[k] = 0; e_ps[k] = 0; e_ms[k] = 0; e_us[k] = 0;
      e_wen[k] = 0; e_yv[k] = 0; e_sv[k] = 0; e_zero[k] = 0;
      e_ya[k] = '0; e_wa[k] = '0; e_wd[k] = '0; e_it[k] = '0; e_sr[k] = '0; e_en[k] = '0;
    end
    s = 2;
    i_st[s] = 1;
    acc = '0;
    for (int i = 0; i < N; i++) begin
      e_yv[s+1+i] = 1; e_ya[s+1+i] = 6'(i);
      e_wen[s+2+i] = 1; e_wa[s+2+i] = 6'(i); e_wd[s+2+i] = y[i];
      sq  = longint'($signed(y[i])) * longint'($signed(y[i]));
      acc = acc + 65'(sq >>> 15);
      if (acc[64]) acc = {1'b0, {64{1'b1}}};
    end
    cur = acc[63:0];
    c = s + N + 2;
    it = 0;
    sr = 0;
    first_p = -1;
    while (1) begin
      if (cur <= rthr) begin sr = 1; break; end
      if (it == rk) begin sr = 2; break; end
      p = c + 1;
      if (first_p < 0) first_p = p;
      e_ps[p] = 1; i_pd[p+lp[it]] = 1;
      m = p + lp[it] + 1;
      e_ms[m] = 1; i_md[m+lm[it]] = 1;
      u = m + lm[it] + 1;
      e_us[u] = 1;
      d = u + lu[it];
      i_ud[d] = 1; i_ue[d] = en[it];
      set_stat(c, d, it, cur, 0);
      it++;
      cur = en[it-1];
      c = d + 1;
    end
    set_stat(c, c, it, cur, 0);
    f = c + 1;
    e_done[f] = 1;
    for (int k = s + 1; k <= f; k++) e_busy[k] = 1;
    set_stat(f, f + 3, it, cur, sr);
    last_cyc = f + 3;
    if (rst_at > 0) begin
      i_rs[rst_at] = 1;
      for (int k = rst_at + 1; k < MAXC; k++) begin
        i_st[k] = 0; i_pd[k] = 0; i_md[k] = 0; i_ud[k] = 0;
        e_busy[k] = 0; e_done[k] = 0; e_ps[k] = 0; e_ms[k] = 0; e_us[k] = 0; e_wen[k] = 0;
        e_zero[k] = 1; e_yv[k] = 1; e_ya[k] = '0; e_wa[k] = '0; e_wd[k] = '0;
        set_stat(k, k, 0, '0, 0);
      end
      i_pd[rst_at+2] = 1;
      last_cyc = rst_at + 6;
    end
  endtask

  always @(negedge clock) begin
    if (active) begin
      check("busy", busy, e_busy[cyc]);
      check("done", done, e_done[cyc]);
      check("products_start", products_start, e_ps[cyc]);
      check("max_start", max_start, e_ms[cyc]);
      check("update_start", update_start, e_us[cyc]);
      check("r_write_en", r_write_en, e_wen[cyc]);
      if (e_wen[cyc] || e_zero[cyc]) begin
        check("r_write_addr", r_write_addr, e_wa[cyc]);
        check("r_write_data", r_write_data, e_wd[cyc]);
      end
      if (e_yv[cyc]) check("y_read_addr", y_read_addr, e_ya[cyc]);
      if (e_sv[cyc]) begin
        check("iteration", iteration, e_it[cyc]);
        check("stop_reason", stop_reason, e_sr[cyc]);
        check("residual_energy", residual_energy, e_en[cyc]);
      end
      if (products_start) n_ps++;
      if (max_start) n_ms++;
      if (update_start) n_us++;
      if (r_write_en) n_wen++;
      if (done) begin
        n_done++; done_at = cyc; d_it = iteration; d_sr = stop_reason; d_en = residual_energy;
      end
    end
  end

  task automatic run(input bit stray);
    logic [5:0] ra;
    plan();
    if (stray && first_p > 0) begin
      i_st[first_p+1] = 1;
      i_md[first_p+2] = 1;
    end
    n_ps = 0; n_ms = 0; n_us = 0; n_wen = 0; n_done = 0; done_at = -1;
    ra = '0;
    active = 1;
    for (int n = 0; n <= last_cyc; n++) begin
      @(posedge clock);
      #1;
      cyc              = n;
      y_read_data      = y[ra];
      reset            = i_rs[n];
      start            = i_st[n];
      products_done    = i_pd[n];
      max_done         = i_md[n];
      update_done      = i_ud[n];
      update_energy    = i_ue[n];
      max_iterations   = i_st[n] ? 8'(rk) : 8'($urandom);
      energy_threshold = i_st[n] ? rthr : {$urandom, $urandom};
      #3;
      ra = y_read_addr;
    end
    @(negedge clock);
    #1;
    active = 0;
  endtask

  task automatic rand_setup(input int shift);
    for (int i = 0; i < N; i++) y[i] = 32'($signed($urandom) >>> shift);
    for (int j = 0; j < 16; j++) begin
      lp[j] = $urandom_range(1, 6); lm[j] = $urandom_range(1, 6); lu[j] = $urandom_range(1, 6);
      en[j] = 64'($urandom_range(0, 2000)) << 10;
    end
    rst_at = -1;
  endtask

  initial begin
    reset = 1; start = 0; products_done = 0; max_done = 0; update_done = 0;
    update_energy = '0; max_iterations = '0; energy_threshold = '0; y_read_data = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_wen", r_write_en, 0);
    check("reset_yaddr", y_read_addr, 0);
    check("reset_iter", iteration, 0);
    check("reset_reason", stop_reason, 0);
    check("reset_energy", residual_energy, 0);
    check("reset_pstart", products_start, 0);
    @(posedge clock);
    #1 reset = 0;

    // Copy only: y[i] = i in Q15, K = 0.
    rand_setup(0);
    for (int i = 0; i < N; i++) y[i] = 32'(i) << 15;
    rk = 0; rthr = '0;
    run(0);
    check("copy_energy", d_en, 64'(85344) << 15);
    check("copy_reason", d_sr, 2);
    check("copy_iter", d_it, 0);
    check("copy_writes", n_wen, 64);

    // Iteration limit with fixed sub-unit latencies.
    rand_setup(0);
    for (int j = 0; j < 16; j++) begin lp[j] = 5; lm[j] = 2; lu[j] = 7; en[j] = 64'(1) << 15; end
    rk = 3; rthr = '0;
    run(0);
    check("limit_pstarts", n_ps, 3);
    check("limit_mstarts", n_ms, 3);
    check("limit_ustarts", n_us, 3);
    check("limit_iter", d_it, 3);
    check("limit_reason", d_sr, 2);
    check("limit_total_cycles", done_at - 2, 66 + 3 * (14 + 4) + 1);

    // Energy stop: 4.0, 1.0, 0.25 against 0.5.
    rand_setup(0);
    en[0] = 64'(4) << 15; en[1] = 64'(1) << 15; en[2] = 64'(1) << 13;
    rk = 8; rthr = 64'(1) << 14;
    run(0);
    check("estop_iter", d_it, 3);
    check("estop_reason", d_sr, 1);

    // Tie at the iteration limit: energy test wins.
    rand_setup(0);
    rthr = 64'(1) << 20; en[0] = rthr + 5; en[1] = rthr; rk = 2;
    run(0);
    check("tie_reason", d_sr, 1);
    check("tie_iter", d_it, 2);

    // Stray start and max_done during PROD.
    rand_setup(0);
    lp[0] = 4; rk = 2; rthr = '0;
    en[0] = 64'(5) << 15; en[1] = 64'(3) << 15;
    run(1);
    check("stray_pstarts", n_ps, 2);
    check("stray_mstarts", n_ms, 2);
    check("stray_reason", d_sr, 2);

    // Reset at copy word 30, then a fresh run.
    rand_setup(0);
    rk = 2; rthr = '0; rst_at = 2 + 2 + 30;
    run(0);
    check("rst_no_done", n_done, 0);
    rand_setup(0);
    rk = 2; rthr = '0;
    run(0);
    check("after_rst_done", n_done, 1);
    check("after_rst_iter", d_it, 2);

    for (int r = 0; r < 6; r++) begin
      rand_setup($urandom_range(0, 30));
      rk = $urandom_range(0, 4);
      rthr = 64'($urandom_range(0, 1000)) << 10;
      run(0);
      check("rand_done", n_done, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
